crc_frame_serializer: RTL and testbench

//  Byte-to-bit serializer for the CRC-16 (x^16+x^12+x^5+1, init FFFF) serial checker.

---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_frame_serializer.sv | 127 ++++++++++++
 tb/tb_crc_frame_serializer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the CRC-16 frame serializer and its CRC stage.
// CRC-16 uses x^16+x^12+x^5+1 with an all-ones seed.
package crc_pkg;

    localparam int          BYTE_W   = 8;
    localparam int          CRC_W    = 16;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic        IDLE_BIT = 1'b1;

    // One counter serves both the payload byte and the CRC tail, so size it for the longer.
    localparam int BITCNT_W = $clog2((CRC_W > BYTE_W) ? CRC_W : BYTE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

endpackage

// File: rtl/crc_frame_serializer.sv
// Byte-to-bit serializer feeding a bit-serial CRC-16 stage; shifts payload MSB-first,
// then streams the CRC stage's register out as the 16-bit frame trailer.
module crc_frame_serializer
    import crc_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              abort,
    input  logic [CRC_W-1:0]  crc_in,
    output logic              crc_data,
    output logic              crc_read,
    output logic              crc_init,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    state_t              state_reg;
    logic [BYTE_W-1:0]   shreg_reg;
    logic [BITCNT_W-1:0] bitcnt_reg;
    logic                last_reg;
    logic                crc_init_reg;
    logic                frame_done_reg;
    logic                underrun_reg;

    logic                byte_boundary;
    logic                accept;
    logic                crc_unused;

    // Only the CRC register's MSB is ever observed; the stage shifts the rest up to it.
    assign crc_unused = ^crc_in[CRC_W-2:0];

    // Last bit of a non-final byte: the next byte must be taken now to avoid a gap.
    assign byte_boundary = (state_reg == DATA) && (bitcnt_reg == '0) && !last_reg;
    assign byte_ready    = !abort && ((state_reg == IDLE) || byte_boundary);
    assign accept        = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            bitcnt_reg     <= '0;
            last_reg       <= 1'b0;
            crc_init_reg   <= 1'b1;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            if (abort) begin
                state_reg    <= IDLE;
                crc_init_reg <= 1'b1;
            end else if (accept) begin
                state_reg    <= DATA;
                shreg_reg    <= byte_data;
                last_reg     <= byte_last;
                bitcnt_reg   <= BITCNT_W'(BYTE_W - 1);
                crc_init_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        crc_init_reg <= 1'b1;
                    end
                    DATA: begin
                        if (bitcnt_reg != '0) begin
                            shreg_reg  <= {shreg_reg[BYTE_W-2:0], 1'b0};
                            bitcnt_reg <= bitcnt_reg - 1'b1;
                        end else if (!last_reg) begin
                            // Next byte was due but not offered: the frame is unrecoverable.
                            state_reg    <= IDLE;
                            crc_init_reg <= 1'b1;
                            underrun_reg <= 1'b1;
                        end else begin
                            state_reg  <= CRC;
                            bitcnt_reg <= BITCNT_W'(CRC_W - 1);
                        end
                    end
                    CRC: begin
                        if (bitcnt_reg == '0) begin
                            state_reg      <= IDLE;
                            crc_init_reg   <= 1'b1;
                            frame_done_reg <= 1'b1;
                        end else begin
                            bitcnt_reg <= bitcnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_reg    <= IDLE;
                        crc_init_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        ser_out  = IDLE_BIT;
        crc_data = 1'b0;
        case (state_reg)
            DATA: begin
                ser_out  = shreg_reg[BYTE_W-1];
                crc_data = shreg_reg[BYTE_W-1];
            end
            CRC: begin
                ser_out = crc_in[CRC_W-1];
            end
            default: begin
                ser_out  = IDLE_BIT;
                crc_data = 1'b0;
            end
        endcase
    end

    assign crc_read   = (state_reg == CRC);
    assign ser_valid  = (state_reg != IDLE);
    assign busy       = (state_reg != IDLE);
    assign crc_init   = crc_init_reg;
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Serializer plus a bit-serial CRC-16 stage, checked cycle by cycle against a frame-level
// model: payload bits MSB-first followed by the byte-wise CRC of the payload.
module tb_crc_frame_serializer;
    import crc_pkg::*;

    logic              clk;
    logic              reset_n;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic              abort;
    logic [CRC_W-1:0]  crc_in;
    logic              crc_data;
    logic              crc_read;
    logic              crc_init;
    logic              ser_out;
    logic              ser_valid;
    logic              busy;
    logic              frame_done;
    logic              underrun;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]  tx[$];
    logic [7:0]  tx_next[$];
    logic [15:0] obs_crc;
    int          valid_cycles;

    crc_frame_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .abort      (abort),
        .crc_in     (crc_in),
        .crc_data   (crc_data),
        .crc_read   (crc_read),
        .crc_init   (crc_init),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    // Downstream CRC stage: crc_init is its synchronous reset, crc_read shifts the result out.
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (crc_init)
            lfsr <= CRC_INIT;
        else if (crc_read)
            lfsr <= {lfsr[14:0], 1'b0};
        else
            lfsr <= {lfsr[14:0], 1'b0} ^ ((lfsr[15] ^ crc_data) ? CRC_POLY : 16'h0000);
    end
    assign crc_in = lfsr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Byte-at-a-time CRC-16 of the current payload.
    function automatic logic [15:0] crc16_ref();
        logic [15:0] c;
        c = CRC_INIT;
        foreach (tx[i]) begin
            c = c ^ {tx[i], 8'h00};
            for (int b = 0; b < 8; b++)
                c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, " byte_ready"}, byte_ready, 1);
        check({tag, " crc_init"},   crc_init,   1);
        check({tag, " crc_read"},   crc_read,   0);
        check({tag, " crc_data"},   crc_data,   0);
        check({tag, " ser_out"},    ser_out,    IDLE_BIT);
        check({tag, " ser_valid"},  ser_valid,  0);
        check({tag, " busy"},       busy,       0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " underrun"},   underrun,   0);
    endtask

    task automatic check_idle(input string tag, input logic exp_done, input logic exp_urun,
                              input logic exp_ready);
        check({tag, " busy"},       busy,       0);
        check({tag, " ser_valid"},  ser_valid,  0);
        check({tag, " ser_out"},    ser_out,    IDLE_BIT);
        check({tag, " crc_init"},   crc_init,   1);
        check({tag, " crc_read"},   crc_read,   0);
        check({tag, " frame_done"}, frame_done, exp_done);
        check({tag, " underrun"},   underrun,   exp_urun);
        check({tag, " byte_ready"}, byte_ready, exp_ready);
    endtask

    // Plays tx through the DUT. drop_at: byte index whose valid is withheld (-1 none);
    // abort_at: stream cycle in which abort is raised (-1 none); preloaded: byte 0 already
    // presented by the previous call; chain: present tx_next[0] in this frame's end cycle.
    task automatic run_frame(input int drop_at, input int abort_at, input bit preloaded,
                             input bit chain);
        int          n;
        int          last_k;
        int          nb;
        logic        exp_bits[$];
        logic [15:0] crc;
        n   = tx.size();
        crc = crc16_ref();
        exp_bits = {};
        foreach (tx[i])
            for (int b = 7; b >= 0; b--) exp_bits.push_back(tx[i][b]);
        for (int b = 15; b >= 0; b--) exp_bits.push_back(crc[b]);
        if (drop_at >= 0)       last_k = 8 * drop_at - 1;
        else if (abort_at >= 0) last_k = abort_at;
        else                    last_k = 8 * n + 15;

        if (!preloaded) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = tx[0];
            byte_last  = (n == 1);
            abort      = 1'b0;
        end
        nb           = 1;
        obs_crc      = '0;
        valid_cycles = 0;

        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            check($sformatf("ser_out k=%0d", k), ser_out, exp_bits[k]);
            check($sformatf("ser_valid k=%0d", k), ser_valid, 1);
            check($sformatf("busy k=%0d", k), busy, 1);
            check($sformatf("crc_init k=%0d", k), crc_init, 0);
            check($sformatf("crc_read k=%0d", k), crc_read, (k >= 8 * n));
            check($sformatf("crc_data k=%0d", k), crc_data, (k < 8 * n) ? exp_bits[k] : 1'b0);
            check($sformatf("byte_ready k=%0d", k), byte_ready,
                  ((k % 8) == 7) && (k < 8 * (n - 1)));
            check($sformatf("frame_done k=%0d", k), frame_done, 0);
            check($sformatf("underrun k=%0d", k), underrun, 0);
            if (ser_valid === 1'b1) valid_cycles++;
            if (k >= 8 * n) obs_crc = {obs_crc[14:0], ser_out};

            abort = (k == abort_at);
            if (nb < n && nb != drop_at) begin
                byte_valid = 1'b1;
                byte_data  = tx[nb];
                byte_last  = (nb == n - 1);
                if (k == 8 * nb - 1) nb++;
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                byte_last  = 1'($urandom);
            end
        end

        @(negedge clk);
        check_idle("end", (drop_at < 0 && abort_at < 0), (drop_at >= 0 && abort_at < 0),
                   (abort_at < 0));
        abort = 1'b0;
        if (chain) begin
            byte_valid = 1'b1;
            byte_data  = tx_next[0];
            byte_last  = (tx_next.size() == 1);
        end else begin
            byte_valid = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check_idle("after", 1'b0, 1'b0, 1'b1);
            end
        end
        $display("frame bytes=%0d drop=%0d abort=%0d chain=%0d crc=%04h",
                 n, drop_at, abort_at, chain, crc);
    endtask

    task automatic fill_next(input int n);
        tx_next = {};
        repeat (n) tx_next.push_back(8'($urandom));
    endtask

    initial begin
        bit pre;
        bit chain;
        int drop;
        int ab;
        int r;

        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        byte_last  = 1'b0;
        abort      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: check string, valid held high throughout
        tx = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(-1, -1, 1'b0, 1'b0);
        check("t1 crc", obs_crc, 16'h29B1);
        check("t1 ser_valid cycles", valid_cycles, 88);

        // 2: single byte
        tx = {8'hA5};
        run_frame(-1, -1, 1'b0, 1'b0);
        check("t2 crc", obs_crc, crc16_ref());

        // 3: underrun at the second boundary, then a clean 0xA5 frame
        tx = {8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame(2, -1, 1'b0, 1'b0);
        tx = {8'hA5};
        run_frame(-1, -1, 1'b0, 1'b0);
        check("t3 crc a5", obs_crc, crc16_ref());

        // 4: abort in bit 3 of byte 2, and in CRC bit 5
        tx = {8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame(-1, 11, 1'b0, 1'b0);
        run_frame(-1, 8 * 3 + 5, 1'b0, 1'b0);

        // 5: asynchronous reset mid-DATA, then the check string again
        tx = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = tx[0];
        byte_last  = 1'b0;
        @(negedge clk);
        byte_data = tx[1];
        repeat (4) @(negedge clk);
        check("t5 busy before reset", busy, 1);
        @(posedge clk);
        #2;
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        #1;
        check_reset_vals("t5 async");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        run_frame(-1, -1, 1'b0, 1'b0);
        check("t5 crc", obs_crc, 16'h29B1);

        // 6: back-to-back frames, second byte_valid in the frame_done cycle
        tx = {8'($urandom), 8'($urandom)};
        fill_next(3);
        run_frame(-1, -1, 1'b0, 1'b1);
        check("t6 crc first", obs_crc, crc16_ref());
        tx = tx_next;
        run_frame(-1, -1, 1'b1, 1'b0);
        check("t6 crc second", obs_crc, crc16_ref());

        // 7: random frames with random chaining, drops and aborts
        pre = 1'b0;
        fill_next($urandom_range(1, 5));
        tx = tx_next;
        for (int f = 0; f < 16; f++) begin
            fill_next($urandom_range(1, 5));
            chain = 1'($urandom_range(0, 1));
            drop  = -1;
            ab    = -1;
            r     = $urandom_range(0, 9);
            if (r < 2 && tx.size() > 1) drop = $urandom_range(1, tx.size() - 1);
            else if (r < 4)             ab   = $urandom_range(0, 8 * tx.size() + 15);
            run_frame(drop, ab, pre, chain);
            if (drop < 0 && ab < 0) check("t7 crc", obs_crc, crc16_ref());
            pre = chain;
            tx  = tx_next;
        end
        if (pre) run_frame(-1, -1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
